// File: rtl/gdp_pkg.sv
// rtl/gdp_pkg.sv - shared GDP numeric type, saturating subtract and score buffer states
package gdp_pkg;

    typedef logic signed [15:0] num;

    localparam num NUM_MIN = 16'sh8000;
    localparam num NUM_MAX = 16'sh7FFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } sb_state_t;

    // a - b computed at 17 bits, then clamped back into the num range
    function automatic num num_sat_sub(input num a, input num b);
        logic signed [16:0] diff;
        diff = 17'(signed'({a[15], a})) - 17'(signed'({b[15], b}));
        if (diff < -17'sd32768) begin
            return NUM_MIN;
        end else if (diff > 17'sd32767) begin
            return NUM_MAX;
        end
        return num'(diff[15:0]);
    endfunction

endpackage

// File: rtl/score_ram.sv
// rtl/score_ram.sv - simple dual-port score RAM with one-cycle registered read
module score_ram
    import gdp_pkg::*;
#(
    parameter int depth = 10,
    parameter int aw    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [aw-1:0] raddr,
    output logic [15:0]   rdata
);

    num mem [0:depth-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/senone_score_buffer.sv
// rtl/senone_score_buffer.sv - captures a frame of senone scores, tracks the best, streams normalised scores
module senone_score_buffer
    import gdp_pkg::*;
#(
    parameter int n_senones = 10,
    parameter int idx_w     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               score_ready,
    input  logic [idx_w-1:0]   senone_idx,
    input  logic signed [15:0] senone_score,
    input  logic               last_senone,
    output logic               busy,
    output logic signed [15:0] best_score,
    output logic [idx_w-1:0]   best_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [idx_w-1:0]   out_idx,
    output logic signed [15:0] out_score,
    output logic               frame_done,
    output logic               overrun
);

    localparam int aw = (n_senones > 1) ? $clog2(n_senones) : 1;
    localparam int cw = idx_w + 1;
    localparam logic [cw-1:0] n_count = cw'(n_senones);

    sb_state_t state, state_nxt;

    logic          score_ready_q;
    logic          cap;
    logic          collecting;
    logic          idx_ok;
    logic          cap_ok;
    logic [cw-1:0] rd_addr;
    logic          rd_all;
    logic          rd_en;
    logic [15:0]   ram_q;

    assign cap        = score_ready && !score_ready_q;
    assign collecting = (state == ST_IDLE) || (state == ST_COLLECT);
    assign idx_ok     = {1'b0, senone_idx} < n_count;
    assign cap_ok     = cap && collecting && idx_ok;
    assign rd_all     = (rd_addr == n_count);
    // Prefetch the next address whenever the output slot is empty or being drained
    assign rd_en      = (state == ST_DRAIN) && !rd_all && (!out_valid || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cap_ok) begin
                    state_nxt = last_senone ? ST_DRAIN : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (cap_ok && last_senone) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready && rd_all) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_ready_q <= 1'b0;
        end else begin
            score_ready_q <= score_ready;
        end
    end

    // First capture of a frame loads unconditionally; ties keep the earlier index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_score <= '0;
            best_idx   <= '0;
        end else if (cap_ok && ((state == ST_IDLE) || (senone_score > best_score))) begin
            best_score <= senone_score;
            best_idx   <= senone_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (cap && (!collecting || !idx_ok)) begin
            overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
        end else if (state != ST_DRAIN) begin
            rd_addr <= '0;
        end else if (rd_en) begin
            rd_addr <= rd_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else if (rd_en) begin
            out_valid <= 1'b1;
            out_idx   <= rd_addr[idx_w-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // RAM read data is held until the next prefetch, so the difference is stable while stalled
    assign out_score = out_valid ? num_sat_sub(num'(ram_q), best_score) : 16'sh0000;

    score_ram #(
        .depth (n_senones),
        .aw    (aw)
    ) u_score_ram (
        .clk   (clk),
        .we    (cap_ok),
        .waddr (senone_idx[aw-1:0]),
        .wdata (senone_score),
        .re    (rd_en),
        .raddr (rd_addr[aw-1:0]),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_senone_score_buffer.sv
// tb/tb_senone_score_buffer.sv - randomized self-checking bench for senone_score_buffer
module tb_senone_score_buffer;

    localparam int N  = 10;
    localparam int IW = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               score_ready;
    logic [IW-1:0]      senone_idx;
    logic signed [15:0] senone_score;
    logic               last_senone;
    logic               busy;
    logic signed [15:0] best_score;
    logic [IW-1:0]      best_idx;
    logic               out_valid;
    logic               out_ready;
    logic [IW-1:0]      out_idx;
    logic signed [15:0] out_score;
    logic               frame_done;
    logic               overrun;

    int n_tests = 0;
    int n_fail  = 0;

    int ref_mem [N];
    int ref_best;
    int ref_best_idx;
    bit ref_first;
    int frame [N];

    senone_score_buffer #(.n_senones(N), .idx_w(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .score_ready  (score_ready),
        .senone_idx   (senone_idx),
        .senone_score (senone_score),
        .last_senone  (last_senone),
        .busy         (busy),
        .best_score   (best_score),
        .best_idx     (best_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_score    (out_score),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int expected_score(input int k);
        int d;
        d = ref_mem[k] - ref_best;
        if (d < -32768) d = -32768;
        return d;
    endfunction

    task automatic present(input int idx, input int score, input bit last, input int hold);
        @(negedge clk);
        score_ready  = 1'b1;
        senone_idx   = IW'(idx);
        senone_score = 16'(score);
        last_senone  = last;
        if (idx < N) begin
            ref_mem[idx] = score;
            if (ref_first || score > ref_best) begin
                ref_best     = score;
                ref_best_idx = idx;
            end
            ref_first = 1'b0;
        end
        repeat (hold) @(negedge clk);
        score_ready = 1'b0;
        last_senone = 1'b0;
    endtask

    // mode 0: always ready, 1: toggle, 2: random; pulse_at >= 0 injects a capture edge
    task automatic drain(input int mode, input int pulse_at);
        int k = 0;
        bit stalled = 1'b0;
        bit done_due = 1'b0;
        bit got_done = 1'b0;
        logic [IW-1:0] s_idx;
        logic [15:0]   s_score;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge clk);
            score_ready  = (cyc == pulse_at);
            senone_idx   = IW'(3);
            senone_score = 16'sh7000;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2) == 0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc == 0) check("drain_start_valid", 32'(out_valid), 32'd1);
            check("busy_in_drain", 32'(busy), 32'd1);
            if (stalled) begin
                check("stall_idx_stable", 32'(out_idx), 32'(s_idx));
                check("stall_score_stable", $unsigned(out_score), 32'(s_score));
            end
            if (done_due) begin
                check("frame_done_timing", 32'(frame_done), 32'd1);
                done_due = 1'b0;
            end
            if (frame_done) begin
                check("frame_done_count", k, N);
                check("valid_low_at_done", 32'(out_valid), 32'd0);
                got_done = 1'b1;
            end else if (out_valid) begin
                if (out_ready) begin
                    if (k < N) begin
                        check("stream_idx", 32'(out_idx), k);
                        check("stream_score", $unsigned(out_score), $unsigned(16'(expected_score(k))));
                    end else begin
                        check("stream_overflow", k, N - 1);
                    end
                    k++;
                    stalled  = 1'b0;
                    done_due = (k == N);
                end else begin
                    stalled = 1'b1;
                    s_idx   = out_idx;
                    s_score = out_score;
                end
            end
        end
        score_ready = 1'b0;
        check("drain_terminated", 32'(got_done), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("frame_done_pulse", 32'(frame_done), 32'd0);
        ref_first = 1'b1;
    endtask

    task automatic run_frame(input int mode, input int pulse_at, input int last_hold);
        for (int i = 0; i < N; i++) begin
            present(i, frame[i], i == N - 1, (i == N - 1) ? last_hold : 1);
            if (i == 0) check("busy_after_first", 32'(busy), 32'd1);
        end
        if (last_hold == 1) check("valid_before_read", 32'(out_valid), 32'd0);
        check("best_score", $unsigned(best_score), $unsigned(16'(ref_best)));
        check("best_idx", 32'(best_idx), ref_best_idx);
        drain(mode, pulse_at);
    endtask

    task automatic check_reset_values();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_best_score", $unsigned(best_score), 32'd0);
        check("rst_best_idx", 32'(best_idx), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_score", $unsigned(out_score), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        score_ready  = 1'b0;
        senone_idx   = '0;
        senone_score = '0;
        last_senone  = 1'b0;
        out_ready    = 1'b0;
        ref_first    = 1'b1;
        ref_best     = 0;
        ref_best_idx = 0;
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        frame = '{16'h12C0, 16'h14C0, 16'h1380, 16'h1200, 16'h17C0,
                  16'h0BC0, 16'h1000, 16'h15C0, 16'h14C0, 16'h14C0};
        run_frame(0, -1, 1);
        check("plan_best", $unsigned(best_score), 32'h17C0);
        check("plan_best_idx", 32'(best_idx), 32'd4);

        for (int i = 0; i < N; i++) frame[i] = int'($signed(16'($urandom)));
        run_frame(1, -1, 1);

        for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(0, 16000)) - 8000;
        frame[2] = 16'h2000;
        frame[6] = 16'h2000;
        run_frame(2, -1, 3);
        check("tie_best_idx", 32'(best_idx), 32'd2);
        check("held_level_no_overrun", 32'(overrun), 32'd0);

        for (int i = 0; i < N; i++) frame[i] = int'($signed(16'($urandom)));
        run_frame(0, 3, 1);
        check("overrun_in_drain", 32'(overrun), 32'd1);

        present(0, 32767, 1'b0, 1);
        present(1, -32767, 1'b1, 1);
        check("sat_best", $unsigned(best_score), 32'h7FFF);
        drain(0, -1);

        for (int i = 0; i < 4; i++) present(i, int'($signed(16'($urandom))), 1'b0, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        reset     = 1'b0;
        ref_first = 1'b1;

        for (int i = 0; i < N; i++) frame[i] = int'($signed(16'($urandom)));
        run_frame(2, -1, 1);

        present(12, 16'h7000, 1'b0, 1);
        @(negedge clk);
        check("bad_idx_overrun", 32'(overrun), 32'd1);
        check("bad_idx_no_capture", 32'(busy), 32'd0);
        check("bad_idx_best_kept", $unsigned(best_score), $unsigned(16'(ref_best)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/senone_score_buffer.md
# senone_score_buffer

Downstream of the GDP controller. Captures each senone score the controller produces for one feature vector and tracks the frame's best score and index. Once the last senone of the frame is in, it streams every score, normalised to the best (score − best), to the next search stage over a valid/ready handshake. It asserts `busy` so the controller is not started on a new vector until the frame has drained.

## Interface
Parameters:
- `n_senones`, default 10: senones per frame; buffer depth; must be ≤ 256.
- `idx_w`, default 8: senone index width, matching the controller's `senone_idx`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `score_ready`  in  1  level from GDP controller; high for ≥1 cycle per score.
- `senone_idx`  in  `idx_w`  index of the presented score; stable while `score_ready` is high.
- `senone_score`  in  num (signed 16)  log-domain score; higher is better.
- `last_senone`  in  1  high alongside the final score of the frame.
- `busy`  out  1  high from the first capture until the drain completes.
- `best_score`  out  num  running maximum for the current frame.
- `best_idx`  out  `idx_w`  index of `best_score`.
- `out_valid`  out  1  normalised score available.
- `out_ready`  in  1  consumer accepts on `out_valid && out_ready`.
- `out_idx`  out  `idx_w`  index of the streamed score.
- `out_score`  out  num  `senone_score − best_score`, saturated, always ≤ 0.
- `frame_done`  out  1  one-cycle pulse after the final transfer.
- `overrun`  out  1  sticky error flag; cleared only by reset.

## Operation
- States:
  - IDLE: no frame in progress.
  - COLLECT: capturing scores.
  - DRAIN: streaming normalised scores.
  - DONE: one cycle, pulses `frame_done`.
- Capture: on a rising edge of `score_ready` (high now, low the previous cycle), write `senone_score` to RAM address `senone_idx`. A level held high captures once.
- IDLE → COLLECT on the first capture. COLLECT → DRAIN in the cycle after the capture that had `last_senone` = 1.
- Best tracking:
  - The first capture of a frame loads `best_score` and `best_idx` unconditionally.
  - A later capture replaces them only if its score is strictly greater; ties keep the earlier index.
- DRAIN:
  - Read addresses 0 … `n_senones`−1 in order.
  - `out_score` = sign-extended 17-bit difference, clamped to 16'h8000 if below −32768.
  - After the transfer at address `n_senones`−1, go to DONE, then IDLE.
  - `best_score` and `best_idx` hold their values through IDLE until the next frame's first capture.
- Overrun: a capture edge in DRAIN or DONE sets `overrun` and the score is dropped.
- Bad index: a capture with `senone_idx` ≥ `n_senones` sets `overrun`; no write, no best update.
- Reset mid-frame: state returns to IDLE. RAM contents need not be cleared.

## Timing
- Reset values: `busy` = 0, `out_valid` = 0, `frame_done` = 0, `overrun` = 0, `best_score` = 0, `best_idx` = 0, `out_idx` = 0, `out_score` = 0.
- `busy` rises in the cycle after the first capture edge and falls in the cycle after `frame_done`.
- Drain start: `out_valid` first rises 2 cycles after the last capture edge (1 cycle state change + 1 cycle synchronous RAM read).
- Handshake:
  - `out_idx` and `out_score` are held stable while `out_valid && !out_ready`.
  - Throughput is one transfer per cycle under continuous `out_ready`; the next address is prefetched on each accept.
  - `out_valid` never drops without a transfer.
- `frame_done` is asserted in the cycle after the final handshake; `out_valid` is 0 in that cycle.

## Structure
- Shared package `gdp_pkg`: `typedef logic signed [15:0] num`, plus a saturating-subtract function `num_sat_sub` reused by the GDP datapath.
- Sub-module `score_ram`: simple dual-port, `n_senones` × num, one write port, registered read with 1-cycle latency.
- The FSM, edge detect, best tracker and output register live in the top module.

## Test plan
- Frame of 10 scores 16'h12C0, 14C0, 1380, 1200, 17C0, 0BC0, 1000, 15C0, 14C0, 14C0 on idx 0–9, `out_ready` = 1:
  - `best_score` = 16'h17C0, `best_idx` = 4.
  - Stream: idx0 → FB00, idx4 → 0000, idx5 → F400.
  - `frame_done` one cycle after idx9.
- Backpressure: toggle `out_ready` 1/0 each cycle → every score delivered exactly once, in order, outputs stable while stalled.
- Ties: scores at idx2 and idx6 both 16'h2000 (the maximum) → `best_idx` = 2.
- Saturation: scores 16'h7FFF (idx0) and 16'h8001 (idx1) → idx1 `out_score` = 16'h8000.
- `score_ready` held high 3 cycles → single capture. A score pulse during DRAIN → `overrun` = 1, stream unchanged.
- Assert `reset` after 4 captures → all outputs at reset values in the same cycle. A full frame afterwards → correct stream and best values.
